// File: rtl/cpu_dbg_pkg.sv
// Shared state encoding and default timing constants for the CPU run controller.
package cpu_dbg_pkg;

  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned SLOW_PERIOD     = CLK_HZ / 2;
  localparam int unsigned FAST_PERIOD     = CLK_HZ / 20;
  localparam int unsigned RESET_HOLD      = 16;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_HOLD   = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_controller_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge press pulse.
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = cpu_dbg_pkg::DEBOUNCE_CYCLES
) (
  input  logic CLK100MHZ,
  input  logic RST,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Level only follows the synced input after it has disagreed for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_in};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync[1];
        r_press <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/cpu_run_controller.sv
// Drives the core's RST_N/HALT: power-on hold, paused, single-step, free-run and timed-tick modes.
module cpu_run_controller
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = cpu_dbg_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned SLOW_PERIOD     = cpu_dbg_pkg::SLOW_PERIOD,
  parameter int unsigned FAST_PERIOD     = cpu_dbg_pkg::FAST_PERIOD,
  parameter int unsigned RESET_HOLD      = cpu_dbg_pkg::RESET_HOLD
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic        sw_free,
  input  logic        sw_fast,
  output logic        cpu_reset_n,
  output logic        cpu_halt,
  output logic        running,
  output logic [31:0] step_count
);

  localparam int unsigned MAX_PERIOD = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
  localparam int unsigned TMR_W      = cnt_width(MAX_PERIOD);
  localparam int unsigned HOLD_W     = cnt_width(RESET_HOLD);

  logic w_step_press, w_run_press;
  logic w_step_level, w_run_level;
  logic w_unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .btn_in    (btn_step),
    .level     (w_step_level),
    .press     (w_step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .btn_in    (btn_run),
    .level     (w_run_level),
    .press     (w_run_press)
  );

  assign w_unused_levels = w_step_level ^ w_run_level;

  logic [1:0]        r_free_sync, r_fast_sync;
  logic              r_free_q, r_fast_q;
  logic              w_free, w_fast, w_sw_chg;
  logic [TMR_W-1:0]  w_period_m1;

  state_e            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_halt, w_halt_nxt;
  logic              r_reset_n, w_reset_n_nxt;
  logic              r_running, w_running_nxt;
  logic [31:0]       r_step_count;

  assign w_free      = r_free_sync[1];
  assign w_fast      = r_fast_sync[1];
  assign w_sw_chg    = (w_free != r_free_q) || (w_fast != r_fast_q);
  assign w_period_m1 = w_fast ? TMR_W'(FAST_PERIOD - 1) : TMR_W'(SLOW_PERIOD - 1);

  // Switch synchronizers plus a delayed copy for change detection.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_free_sync <= '0;
      r_fast_sync <= '0;
      r_free_q    <= 1'b0;
      r_fast_q    <= 1'b0;
    end else begin
      r_free_sync <= {r_free_sync[0], sw_free};
      r_fast_sync <= {r_fast_sync[0], sw_fast};
      r_free_q    <= w_free;
      r_fast_q    <= w_fast;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_state   <= ST_HOLD;
      r_timer   <= '0;
      r_hold    <= '0;
      r_halt    <= 1'b1;
      r_reset_n <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_hold    <= w_hold_nxt;
      r_halt    <= w_halt_nxt;
      r_reset_n <= w_reset_n_nxt;
      r_running <= w_running_nxt;
    end
  end

  // Next state and registered-output values; the timer is zero outside RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = '0;
    w_hold_nxt    = r_hold;
    w_halt_nxt    = 1'b1;
    w_reset_n_nxt = r_reset_n;
    w_running_nxt = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_hold == HOLD_W'(RESET_HOLD - 1)) begin
          w_state_nxt   = ST_PAUSED;
          w_reset_n_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      ST_PAUSED: begin
        if (w_run_press) begin
          w_state_nxt   = ST_RUN;
          w_running_nxt = 1'b1;
          w_halt_nxt    = !w_free;
        end else if (w_step_press) begin
          w_state_nxt = ST_STEP;
          w_halt_nxt  = 1'b0;
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_PAUSED;
      end
      ST_RUN: begin
        if (w_run_press) begin
          w_state_nxt = ST_PAUSED;
        end else begin
          w_running_nxt = 1'b1;
          if (w_free) begin
            w_halt_nxt = 1'b0;
          end else if (w_sw_chg) begin
            w_timer_nxt = '0;
          end else if (r_timer >= w_period_m1) begin
            w_halt_nxt = 1'b0;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  // Counts clocks the core actually advanced; sticks at all-ones.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_step_count <= '0;
    end else if (!r_halt && r_reset_n && (r_step_count != '1)) begin
      r_step_count <= r_step_count + 32'd1;
    end
  end

  assign cpu_reset_n = r_reset_n;
  assign cpu_halt    = r_halt;
  assign running     = r_running;
  assign step_count  = r_step_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller with shortened timing parameters.
module tb_cpu_run_controller;

  logic        CLK100MHZ;
  logic        RST;
  logic        btn_step, btn_run, sw_free, sw_fast;
  logic        cpu_reset_n, cpu_halt, running;
  logic [31:0] step_count;

  int n_checks = 0;
  int n_fails  = 0;
  int zeros;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES (4),
    .SLOW_PERIOD     (8),
    .FAST_PERIOD     (2),
    .RESET_HOLD      (3)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .RST         (RST),
    .btn_step    (btn_step),
    .btn_run     (btn_run),
    .sw_free     (sw_free),
    .sw_fast     (sw_fast),
    .cpu_reset_n (cpu_reset_n),
    .cpu_halt    (cpu_halt),
    .running     (running),
    .step_count  (step_count)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Advance until running matches want (bounded); counts halt=0 samples on the way.
  task automatic wait_run(input logic want, input string tag, output int nz);
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!cpu_halt) nz++;
      if (running == want) break;
    end
    check(tag, 32'(running), 32'(want));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; btn_step = 1'b0; btn_run = 1'b0; sw_free = 1'b0; sw_fast = 1'b0;

    // 1: reset values and power-on hold
    tick(); tick();
    check("rst_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_halt", 32'(cpu_halt), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_count", step_count, 32'd0);
    RST = 1'b0;
    check("hold0_reset_n", 32'(cpu_reset_n), 32'd0);
    tick();
    check("hold1_reset_n", 32'(cpu_reset_n), 32'd0);
    check("hold1_halt", 32'(cpu_halt), 32'd1);
    tick();
    check("hold2_reset_n", 32'(cpu_reset_n), 32'd0);
    tick();
    check("hold_done_reset_n", 32'(cpu_reset_n), 32'd1);
    check("hold_done_halt", 32'(cpu_halt), 32'd1);
    check("hold_done_count", step_count, 32'd0);

    // 2: glitches then a held step press
    zeros = 0;
    for (int g = 0; g < 3; g++) begin
      btn_step = 1'b1; tick(); if (!cpu_halt) zeros++;
      btn_step = 1'b0;
      for (int j = 0; j < 3; j++) begin tick(); if (!cpu_halt) zeros++; end
    end
    check("glitch_no_step", 32'(zeros), 32'd0);
    btn_step = 1'b1;
    for (int j = 0; j < 10; j++) begin tick(); if (!cpu_halt) zeros++; end
    btn_step = 1'b0;
    for (int j = 0; j < 10; j++) begin tick(); if (!cpu_halt) zeros++; end
    check("step_one_clock", 32'(zeros), 32'd1);
    check("step_count1", step_count, 32'd1);
    check("step_running", 32'(running), 32'd0);

    // 3: timed ticks, slow period
    btn_run = 1'b1;
    wait_run(1'b1, "run_enter", zeros);
    check("run_entry_halt", 32'(cpu_halt), 32'd1);
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 4) btn_run = 1'b0;
      if (k <= 24) check($sformatf("slow_halt_k%0d", k), 32'(cpu_halt), (k % 8 == 0) ? 32'd0 : 32'd1);
    end
    check("slow_count", step_count, 32'd4);
    check("slow_running", 32'(running), 32'd1);

    // 4: free-run then pause
    sw_free = 1'b1;
    tick(); tick();
    zeros = 0;
    for (int j = 0; j < 18; j++) begin tick(); if (!cpu_halt) zeros++; end
    check("free_every_clock", 32'(zeros), 32'd18);
    check("free_count", step_count, 32'd21);
    btn_run = 1'b1;
    wait_run(1'b0, "pause_enter", zeros);
    btn_run = 1'b0;
    sw_free = 1'b0;
    check("pause_halt", 32'(cpu_halt), 32'd1);
    check("pause_count", step_count, 32'd28);
    for (int j = 0; j < 10; j++) tick();
    check("pause_count_frozen", step_count, 32'd28);
    check("pause_halt_held", 32'(cpu_halt), 32'd1);

    // 5: simultaneous step+run, then fast switch mid-period
    btn_step = 1'b1; btn_run = 1'b1;
    wait_run(1'b1, "both_run_enter", zeros);
    check("both_no_step_clock", 32'(zeros), 32'd0);
    check("both_entry_halt", 32'(cpu_halt), 32'd1);
    check("both_count", step_count, 32'd28);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) sw_fast = 1'b1;
      if (k == 4) begin btn_step = 1'b0; btn_run = 1'b0; end
      check($sformatf("fast_halt_k%0d", k), 32'(cpu_halt),
            (k == 8 || k == 10 || k == 12) ? 32'd0 : 32'd1);
    end
    check("fast_count", step_count, 32'd30);

    // 6: saturation via preload, then reset mid-tick
    sw_free = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    @(negedge CLK100MHZ);
    force dut.r_step_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_step_count;
    tick();
    check("sat_reach", step_count, 32'hFFFF_FFFF);
    tick();
    check("sat_hold", step_count, 32'hFFFF_FFFF);
    tick();
    check("sat_hold2", step_count, 32'hFFFF_FFFF);
    sw_free = 1'b0; sw_fast = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    RST = 1'b1;
    tick();
    check("midrst_reset_n", 32'(cpu_reset_n), 32'd0);
    check("midrst_halt", 32'(cpu_halt), 32'd1);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_count", step_count, 32'd0);
    RST = 1'b0;
    tick(); tick();
    check("rehold_reset_n", 32'(cpu_reset_n), 32'd0);
    tick();
    check("rehold_done_reset_n", 32'(cpu_reset_n), 32'd1);
    check("rehold_running", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
